uc_seq: RTL and testbench

Sequenced control unit for the single-cycle microcontroller datapath. It decodes the 6-bit `opcode` and the registered zero flag `z` from the datapath into the control lines `s_inc`, `s_inm`, `we3`, `wez` and `op`. It adds a PC enable `pc_en`, which the core top level wires to the enable of the PC register. A small state machine implements boot hold, multi-cycle WAIT, and HALT/resume, so the block is the controlling end of the datapath's opcode/z ↔ control interface.

---
 rtl/uc_seq_pkg.sv | 67 ++++++
 rtl/uc_seq_if.sv | 22 ++
 rtl/uc_seq_dec.sv | 47 ++++
 rtl/uc_seq.sv | 110 +++++++++++
 tb/tb_uc_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_seq_pkg.sv
// Shared definitions for the microcontroller control path: state encoding,
// opcode classes and ALU operation codes used by both control unit and datapath.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAITING = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LI   = 3'd1,
        CLS_NOP  = 3'd2,
        CLS_WAIT = 3'd3,
        CLS_J    = 3'd4,
        CLS_JZ   = 3'd5,
        CLS_JNZ  = 3'd6,
        CLS_HALT = 3'd7
    } opc_class_t;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'b000,
        ALU_NOT_A  = 3'b001,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_NEG_A  = 3'b110,
        ALU_NEG_B  = 3'b111
    } alu_op_t;

    localparam logic [3:0] GRP_LI   = 4'b0000;
    localparam logic [3:0] GRP_NOP  = 4'b0001;
    localparam logic [3:0] GRP_WAIT = 4'b0011;
    localparam logic [3:0] GRP_JUMP = 4'b0100;

    localparam logic [5:0] OPC_J    = 6'b010000;
    localparam logic [5:0] OPC_JZ   = 6'b010001;
    localparam logic [5:0] OPC_JNZ  = 6'b010010;
    localparam logic [5:0] OPC_HALT = 6'b010011;

    localparam logic [2:0] ALU_OP_IDLE = ALU_PASS_A;

    function automatic logic opc_legal(input logic [5:0] opc);
        logic [3:0] grp;
        grp = opc[5:2];
        return opc[5] || (grp == GRP_LI) || (grp == GRP_NOP) ||
               (grp == GRP_WAIT) || (grp == GRP_JUMP);
    endfunction

    // Undefined opcodes fall back to NOP so the core keeps stepping.
    function automatic opc_class_t classify(input logic [5:0] opc);
        opc_class_t cls;
        cls = CLS_NOP;
        if (opc[5])                   cls = CLS_ALU;
        else if (opc[5:2] == GRP_LI)  cls = CLS_LI;
        else if (opc[5:2] == GRP_WAIT) cls = CLS_WAIT;
        else if (opc == OPC_J)        cls = CLS_J;
        else if (opc == OPC_JZ)       cls = CLS_JZ;
        else if (opc == OPC_JNZ)      cls = CLS_JNZ;
        else if (opc == OPC_HALT)     cls = CLS_HALT;
        return cls;
    endfunction

endpackage

// File: rtl/uc_seq_if.sv
// Opcode/zero-flag to control-line link between the control unit (master)
// and the single-cycle datapath (slave).
interface uc_seq_if;
    logic [5:0] opcode;
    logic       z;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       pc_en;

    modport master (
        input  opcode, z,
        output s_inc, s_inm, we3, wez, op, pc_en
    );

    modport slave (
        output opcode, z,
        input  s_inc, s_inm, we3, wez, op, pc_en
    );
endinterface

// File: rtl/uc_seq_dec.sv
// Pure combinational instruction decoder: opcode and zero flag to raw control
// lines, plus class strobes the sequencer uses for its state decisions.
module uc_dec
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op,
    output logic       is_wait,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        wez        = 1'b0;
        op         = ALU_OP_IDLE;
        is_wait    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = !opc_legal(opcode);

        case (classify(opcode))
            CLS_ALU: begin
                op  = opcode[4:2];
                we3 = 1'b1;
                wez = 1'b1;
            end
            CLS_LI: begin
                s_inm = 1'b1;
                we3   = 1'b1;
            end
            CLS_WAIT: is_wait = 1'b1;
            CLS_J:    s_inc   = 1'b0;
            CLS_JZ:   s_inc   = ~z;
            CLS_JNZ:  s_inc   = z;
            CLS_HALT: is_halt = 1'b1;
            default:  s_inc   = 1'b1;
        endcase
    end

endmodule

// File: rtl/uc_seq.sv
// Sequenced control unit: boot hold, multi-cycle WAIT and HALT/resume wrapped
// around the instruction decoder, with Mealy outputs and a sticky illegal flag.
module uc_seq
    import uc_pkg::*;
#(
    parameter int WAIT_W = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  logic     resume,
    uc_seq_if.master bus,
    output logic     halted,
    output logic     illegal
);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;
    logic              illegal_nxt;

    logic       d_s_inc;
    logic       d_s_inm;
    logic       d_we3;
    logic       d_wez;
    logic [2:0] d_op;
    logic       d_is_wait;
    logic       d_is_halt;
    logic       d_is_illegal;

    uc_dec u_dec (
        .opcode     (bus.opcode),
        .z          (bus.z),
        .s_inc      (d_s_inc),
        .s_inm      (d_s_inm),
        .we3        (d_we3),
        .wez        (d_wez),
        .op         (d_op),
        .is_wait    (d_is_wait),
        .is_halt    (d_is_halt),
        .is_illegal (d_is_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_BOOT;
            cnt     <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            illegal <= illegal_nxt;
        end
    end

    // Only RUN passes decoder lines through; every other state forces the
    // defaults so no register or flag write can leak out while stalled.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        illegal_nxt = illegal;
        bus.pc_en   = 1'b0;
        bus.s_inc   = 1'b1;
        bus.s_inm   = 1'b0;
        bus.we3     = 1'b0;
        bus.wez     = 1'b0;
        bus.op      = ALU_OP_IDLE;
        halted      = 1'b0;

        case (state)
            ST_BOOT: begin
                halted = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                bus.pc_en   = 1'b1;
                bus.s_inc   = d_s_inc;
                bus.s_inm   = d_s_inm;
                bus.we3     = d_we3;
                bus.wez     = d_wez;
                bus.op      = d_op;
                illegal_nxt = illegal | d_is_illegal;
                if (d_is_wait) begin
                    bus.pc_en = 1'b0;
                    cnt_nxt   = WAIT_W'(bus.opcode[1:0]);
                    state_nxt = ST_WAITING;
                end else if (d_is_halt) begin
                    bus.pc_en = 1'b0;
                    state_nxt = ST_HALTED;
                end
            end
            ST_WAITING: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - WAIT_W'(1);
                end else begin
                    bus.pc_en = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    bus.pc_en = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: directed scenarios with literal expectations
// followed by randomized stimulus against an instruction-level reference model.
module tb_uc_seq;

    logic clk;
    logic reset;
    logic start;
    logic resume;
    logic halted;
    logic illegal;

    uc_seq_if bus ();

    uc_seq #(.WAIT_W(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .resume  (resume),
        .bus     (bus),
        .halted  (halted),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: where the machine is, in instruction-level terms.
    bit m_booting;
    bit m_halted;
    int m_stall_left;   // -1 when not stalling in a WAIT
    bit m_illegal;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booting    = 1;
        m_halted     = 0;
        m_stall_left = -1;
        m_illegal    = 0;
    endtask

    function automatic bit opc_defined(input int o);
        int grp;
        grp = o / 4;
        return (o >= 32) || grp == 0 || grp == 1 || grp == 3 || grp == 4;
    endfunction

    task automatic compare_model();
        int o, grp;
        int e_pc, e_inc, e_inm, e_we3, e_wez, e_op, e_halt;
        o = int'(bus.opcode);
        grp = o / 4;
        e_pc = 0; e_inc = 1; e_inm = 0; e_we3 = 0; e_wez = 0; e_op = 0; e_halt = 0;
        if (m_booting) begin
            e_halt = 1;
        end else if (m_halted) begin
            e_halt = 1;
            e_pc = resume ? 1 : 0;
        end else if (m_stall_left >= 0) begin
            e_pc = (m_stall_left == 0) ? 1 : 0;
        end else begin
            e_pc = 1;
            if (o >= 32) begin
                e_op = grp % 8; e_we3 = 1; e_wez = 1;
            end else if (grp == 0) begin
                e_inm = 1; e_we3 = 1;
            end else if (grp == 3) begin
                e_pc = 0;
            end else if (o == 16) begin
                e_inc = 0;
            end else if (o == 17) begin
                e_inc = bus.z ? 0 : 1;
            end else if (o == 18) begin
                e_inc = bus.z ? 1 : 0;
            end else if (o == 19) begin
                e_pc = 0;
            end
        end
        chk("m_pc_en",   32'(bus.pc_en), 32'(e_pc));
        chk("m_s_inc",   32'(bus.s_inc), 32'(e_inc));
        chk("m_s_inm",   32'(bus.s_inm), 32'(e_inm));
        chk("m_we3",     32'(bus.we3),   32'(e_we3));
        chk("m_wez",     32'(bus.wez),   32'(e_wez));
        chk("m_op",      32'(bus.op),    32'(e_op));
        chk("m_halted",  32'(halted),    32'(e_halt));
        chk("m_illegal", 32'(illegal),   32'(m_illegal));
    endtask

    task automatic model_step();
        int o;
        o = int'(bus.opcode);
        if (reset) begin
            model_reset();
        end else if (m_booting) begin
            if (start) m_booting = 0;
        end else if (m_halted) begin
            if (resume) m_halted = 0;
        end else if (m_stall_left > 0) begin
            m_stall_left--;
        end else if (m_stall_left == 0) begin
            m_stall_left = -1;
        end else begin
            if (o / 4 == 3) m_stall_left = o % 4;
            if (o == 19) m_halted = 1;
            if (!opc_defined(o)) m_illegal = 1;
        end
    endtask

    // Drive inputs just after the edge, compare mid-cycle against the model.
    task automatic apply(input logic [5:0] opc, input logic zz, input logic st,
                         input logic rs, input logic rst_v);
        bus.opcode = opc;
        bus.z      = zz;
        start      = st;
        resume     = rs;
        reset      = rst_v;
        if (rst_v) model_reset();
        #4;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        model_reset();

        // Reset state
        apply(6'b000100, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_we3", 32'(bus.we3), 32'd0);
        chk("rst_s_inc", 32'(bus.s_inc), 32'd1);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_illegal", 32'(illegal), 32'd0);
        tick();

        // Boot hold
        for (int i = 0; i < 3; i++) begin
            apply(6'b101100, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("boot_pc_en", 32'(bus.pc_en), 32'd0);
            chk("boot_we3", 32'(bus.we3), 32'd0);
            chk("boot_halted", 32'(halted), 32'd1);
            tick();
        end
        apply(6'b101100, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_cyc_pc_en", 32'(bus.pc_en), 32'd0);
        tick();

        // ALU and LI
        apply(6'b101100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("run_pc_en", 32'(bus.pc_en), 32'd1);
        chk("run_halted", 32'(halted), 32'd0);
        chk("alu_op", 32'(bus.op), 32'd3);
        chk("alu_we3", 32'(bus.we3), 32'd1);
        chk("alu_wez", 32'(bus.wez), 32'd1);
        chk("alu_s_inm", 32'(bus.s_inm), 32'd0);
        chk("alu_s_inc", 32'(bus.s_inc), 32'd1);
        tick();
        apply(6'b000011, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("li_s_inm", 32'(bus.s_inm), 32'd1);
        chk("li_we3", 32'(bus.we3), 32'd1);
        chk("li_wez", 32'(bus.wez), 32'd0);
        tick();

        // Conditional jumps
        apply(6'b010001, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jz_z1", 32'(bus.s_inc), 32'd0);
        tick();
        apply(6'b010001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jz_z0", 32'(bus.s_inc), 32'd1);
        tick();
        apply(6'b010010, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jnz_z1", 32'(bus.s_inc), 32'd1);
        tick();
        apply(6'b010010, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("jnz_z0", 32'(bus.s_inc), 32'd0);
        tick();
        apply(6'b010000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("j_s_inc", 32'(bus.s_inc), 32'd0);
        tick();

        // WAIT k=2: three held cycles then release
        for (int i = 0; i < 3; i++) begin
            apply(6'b001110, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("wait_pc_en", 32'(bus.pc_en), 32'd0);
            chk("wait_we3", 32'(bus.we3), 32'd0);
            tick();
        end
        apply(6'b001110, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wait_end_pc_en", 32'(bus.pc_en), 32'd1);
        chk("wait_end_s_inc", 32'(bus.s_inc), 32'd1);
        tick();
        apply(6'b100000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_wait_we3", 32'(bus.we3), 32'd1);
        tick();

        // HALT and resume
        for (int i = 0; i < 4; i++) begin
            apply(6'b010011, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("halt_pc_en", 32'(bus.pc_en), 32'd0);
            chk("halt_we3", 32'(bus.we3), 32'd0);
            if (i > 0) chk("halt_halted", 32'(halted), 32'd1);
            tick();
        end
        apply(6'b010011, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_pc_en", 32'(bus.pc_en), 32'd1);
        chk("resume_s_inc", 32'(bus.s_inc), 32'd1);
        tick();
        apply(6'b000100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_resume_halted", 32'(halted), 32'd0);
        chk("post_resume_pc_en", 32'(bus.pc_en), 32'd1);
        tick();

        // Illegal opcode behaves as NOP and is sticky
        apply(6'b011100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ill_we3", 32'(bus.we3), 32'd0);
        chk("ill_pc_en", 32'(bus.pc_en), 32'd1);
        tick();
        apply(6'b110000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ill_sticky0", 32'(illegal), 32'd1);
        tick();
        apply(6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ill_sticky1", 32'(illegal), 32'd1);
        tick();

        // Reset in the middle of a WAIT k=3
        apply(6'b001111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(6'b001111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        apply(6'b001111, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrst_halted", 32'(halted), 32'd1);
        chk("wrst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("wrst_illegal", 32'(illegal), 32'd0);
        tick();
        apply(6'b001101, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // WAIT k=1 right after reset must still be exactly two held cycles
        for (int i = 0; i < 2; i++) begin
            apply(6'b001101, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("w1_pc_en", 32'(bus.pc_en), 32'd0);
            tick();
        end
        apply(6'b001101, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("w1_end_pc_en", 32'(bus.pc_en), 32'd1);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] opc;
            logic       zz, st, rs, rr;
            opc = 6'($urandom_range(0, 63));
            zz  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 3) == 0);
            rs  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 199) == 0);
            apply(opc, zz, st, rs, rr);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
